sopc_run_ctrl: RTL



---
 rtl/sopc_run_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run controller for the minimal RISC-V SoPC.
// Sequences the core reset, counts RUN cycles, watches the data-memory
// store port for a write to the tohost address and reports pass, fail
// code or watchdog timeout. The verdict is sticky until rst.
// Optional feature: define SOPC_RUN_CTRL_HEARTBEAT_EN to add the
// heartbeat output (blinks in RUN, shows the verdict in DONE).
module sopc_run_ctrl #(
    parameter int unsigned        RST_HOLD     = 10,
    parameter int unsigned        CNT_W        = 32,
    parameter int unsigned        MAX_CYCLES   = 500,
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR  = ADDR_W'(32'h0000_1000),
    parameter bit                 HALT_ON_DONE = 1'b1
`ifdef SOPC_RUN_CTRL_HEARTBEAT_EN
    ,
    parameter int unsigned        HB_DIV       = 25_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              running,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code
`ifdef SOPC_RUN_CTRL_HEARTBEAT_EN
    ,
    output logic              heartbeat
`endif
);

    // Hold counter only has to reach RST_HOLD-1.
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    // Watchdog fires on the last allowed RUN cycle; MAX_CYCLES=0 disables it.
    localparam bit LP_WD_EN = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] LP_TO_LAST =
        (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_core_rst;
    logic                r_running;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [DATA_W-2:0]   r_fail_code;

    logic                w_hit;
    logic                w_hit_pass;
    logic                w_wd_expire;

    // A tohost hit is a store strobe to the magic address; value 1 means pass.
    assign w_hit       = mem_we && (mem_addr == TOHOST_ADDR);
    assign w_hit_pass  = (mem_wdata == DATA_W'(1));
    assign w_wd_expire = LP_WD_EN && (r_cycle_cnt == LP_TO_LAST);

    // Run-control FSM: reset sequencing, cycle counting and verdict capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_core_rst  <= 1'b1;
            r_running   <= 1'b0;
            r_cycle_cnt <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_code <= '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    // Release the core once it has seen RST_HOLD reset cycles.
                    if (r_hold_cnt == LP_HOLD_LAST) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b0;
                        r_running  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    // The cycle that ends the run is still counted.
                    if (r_cycle_cnt != '1) begin
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    end
                    // A hit takes priority over a simultaneous watchdog expiry.
                    if (w_hit) begin
                        r_state     <= ST_DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_core_rst  <= HALT_ON_DONE;
                        r_pass      <= w_hit_pass;
                        r_timeout   <= 1'b0;
                        r_fail_code <= w_hit_pass ? '0 : mem_wdata[DATA_W-1:1];
                    end else if (w_wd_expire) begin
                        r_state     <= ST_DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_core_rst  <= HALT_ON_DONE;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_fail_code <= '0;
                    end
                end

                ST_DONE: begin
                    // Verdict and counter are frozen; only rst leaves DONE.
                    r_state <= ST_DONE;
                end

                default: begin
                    r_state     <= ST_HOLD;
                    r_hold_cnt  <= '0;
                    r_core_rst  <= 1'b1;
                    r_running   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SOPC_RUN_CTRL_HEARTBEAT_EN
    localparam int unsigned HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0] LP_HB_LAST = HB_W'(HB_DIV - 1);

    logic [HB_W-1:0] r_hb_cnt;
    logic            r_heartbeat;

    // Heartbeat: dark in HOLD, blinks in RUN, shows pass/fail in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hit) begin
                        r_heartbeat <= w_hit_pass;
                    end else if (w_wd_expire) begin
                        r_heartbeat <= 1'b0;
                    end else if (r_hb_cnt == LP_HB_LAST) begin
                        r_hb_cnt    <= '0;
                        r_heartbeat <= ~r_heartbeat;
                    end else begin
                        r_hb_cnt    <= r_hb_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_heartbeat <= r_pass;
                end
                default: begin
                    r_hb_cnt    <= '0;
                    r_heartbeat <= 1'b0;
                end
            endcase
        end
    end

    assign heartbeat = r_heartbeat;
`endif

    assign core_rst  = r_core_rst;
    assign running   = r_running;
    assign cycle_cnt = r_cycle_cnt;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign fail_code = r_fail_code;

endmodule
